tcu_reset_seq: RTL and testbench

Sequences soft-reset requests for several TCU sub-domains (ctrl, NoC IF, cache IF, register file) and shares the reset resource between requesters: privileged register write, NoC command and watchdog.
- Arbitrates requesters round-robin.
- Holds the selected domains in reset for a fixed time, then releases them one by one in ascending index order.
- Each dom_reset_n_o feeds a per-domain util_reset_sync together with reset_n_i.

---
 rtl/tcu_reset_seq_pkg.sv | 26 ++
 rtl/tcu_rr_arbiter.sv | 43 ++++
 rtl/tcu_reset_seq.sv | 169 ++++++++++++++++
 tb/tb_tcu_reset_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcu_reset_seq_pkg.sv
// Shared types and helpers for the TCU soft-reset sequencer.
// Optional cause/count reporting is enabled by defining TCU_RESET_SEQ_CAUSE_EN.
package tcu_reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_ASSERT  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int unsigned            RST_CNT_W   = 8;
    localparam logic [RST_CNT_W-1:0]   RST_CNT_MAX = 8'hFF;

    // Down-counter width wide enough for the longer of the hold and gap intervals.
    function automatic int unsigned cnt_w(input int unsigned hold, input int unsigned gap);
        return $clog2((hold > gap) ? hold : gap) + 1;
    endfunction

    // Requester index / cause width; kept at least one bit for a single requester.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcu_rr_arbiter.sv
// Round-robin requester select: combinational grant, pointer advances past
// the winner when en is high.
module tcu_rr_arbiter
    import tcu_reset_seq_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [IDX_W-1:0]   win,
    output logic [IDX_W-1:0]   gnt_idx_c,
    output logic               gnt_vld_c
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the closest pending request to ptr wins.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        cand      = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_q) + i) % int'(NUM_REQ));
            if (req[cand]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
        end
    end

endmodule

// File: rtl/tcu_reset_seq.sv
// TCU soft-reset sequencer: grants one requester at a time, holds its domains
// in reset, then releases them in ascending order. Define TCU_RESET_SEQ_CAUSE_EN
// to add cause_o / cause_vld_o / rst_cnt_o reporting.
module tcu_reset_seq
    import tcu_reset_seq_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 3,
    parameter  int unsigned NUM_DOM     = 4,
    parameter  int unsigned HOLD_CYCLES = 16,
    parameter  int unsigned GAP_CYCLES  = 4,
    localparam int unsigned REQ_W       = idx_w(NUM_REQ)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*NUM_DOM-1:0] dom_mask_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic [NUM_DOM-1:0]         dom_reset_n_o,
    output logic                       busy_o
`ifdef TCU_RESET_SEQ_CAUSE_EN
    ,
    output logic [REQ_W-1:0]           cause_o,
    output logic                       cause_vld_o,
    output logic [RST_CNT_W-1:0]       rst_cnt_o
`endif
);

    localparam int unsigned      CNT_W     = cnt_w(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_e               state_q, state_d;
    logic [REQ_W-1:0]     win_q, win_d;
    logic [NUM_DOM-1:0]   rem_q, rem_d;
    logic [NUM_DOM-1:0]   dom_q, dom_d;
    logic [NUM_DOM-1:0]   lo_oh;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic [REQ_W-1:0]     gnt_idx;
    logic                 gnt_vld;
    logic                 adv;

    assign adv = (state_q == ST_GRANT);

    tcu_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk_i),
        .rst_n     (reset_n_i),
        .req       (req_i),
        .en        (adv),
        .win       (win_q),
        .gnt_idx_c (gnt_idx),
        .gnt_vld_c (gnt_vld)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            rem_q   <= '0;
            dom_q   <= '1;
            cnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rem_q   <= rem_d;
            dom_q   <= dom_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // rem tracks masked domains still held low; lo_oh is its lowest set bit.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        rem_d   = rem_q;
        dom_d   = dom_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        lo_oh   = rem_q & (~rem_q + NUM_DOM'(1));

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d = ST_GRANT;
                    win_d   = gnt_idx;
                    rem_d   = dom_mask_i[int'(gnt_idx)*NUM_DOM +: NUM_DOM];
                end
            end
            ST_GRANT: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                    ack_d   = NUM_REQ'(1) << win_q;
                end else begin
                    state_d = ST_ASSERT;
                    cnt_d   = HOLD_LOAD;
                    dom_d   = ~rem_q;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RELEASE;
                    dom_d   = dom_q | lo_oh;
                    rem_d   = rem_q & ~lo_oh;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                    ack_d   = NUM_REQ'(1) << win_q;
                end else if (cnt_q == '0) begin
                    dom_d = dom_q | lo_oh;
                    rem_d = rem_q & ~lo_oh;
                    cnt_d = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign ack_o         = ack_q;
    assign dom_reset_n_o = dom_q;
    assign busy_o        = busy_q;

`ifdef TCU_RESET_SEQ_CAUSE_EN
    logic [REQ_W-1:0]     cause_q;
    logic                 cause_vld_q;
    logic [RST_CNT_W-1:0] rst_cnt_q;
    logic                 done_entry;

    assign done_entry = (state_d == ST_DONE) && (state_q != ST_DONE);

    // Cause and count become visible in the DONE cycle alongside ack.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cause_q     <= '0;
            cause_vld_q <= 1'b0;
            rst_cnt_q   <= '0;
        end else if (done_entry) begin
            cause_q     <= win_q;
            cause_vld_q <= 1'b1;
            rst_cnt_q   <= (rst_cnt_q == RST_CNT_MAX) ? rst_cnt_q : rst_cnt_q + RST_CNT_W'(1);
        end
    end

    assign cause_o     = cause_q;
    assign cause_vld_o = cause_vld_q;
    assign rst_cnt_o   = rst_cnt_q;
`endif

endmodule

// File: tb/tb_tcu_reset_seq.sv
// Scoreboard bench for tcu_reset_seq: expected domain transitions and acks are
// queued by the stimulus and matched by an independent monitor.
module tb_tcu_reset_seq;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [2:0]  req_i;
    logic [11:0] dom_mask_i;
    logic [2:0]  ack_o;
    logic [3:0]  dom_reset_n_o;
    logic        busy_o;
`ifdef TCU_RESET_SEQ_CAUSE_EN
    logic [1:0]  cause_o;
    logic        cause_vld_o;
    logic [7:0]  rst_cnt_o;
`endif

    tcu_reset_seq dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .req_i         (req_i),
        .dom_mask_i    (dom_mask_i),
        .ack_o         (ack_o),
        .dom_reset_n_o (dom_reset_n_o),
        .busy_o        (busy_o)
`ifdef TCU_RESET_SEQ_CAUSE_EN
        ,
        .cause_o       (cause_o),
        .cause_vld_o   (cause_vld_o),
        .rst_cnt_o     (rst_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } dom_ev_t;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } ack_ev_t;

    dom_ev_t dq[$];
    ack_ev_t aq[$];
    int checks = 0;
    int errors = 0;

    task automatic push_dom(input int c, input logic [3:0] v);
        dom_ev_t e;
        e.cyc = c;
        e.val = v;
        dq.push_back(e);
    endtask

    task automatic push_ack(input int c, input logic [2:0] v);
        ack_ev_t e;
        e.cyc = c;
        e.val = v;
        aq.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2000 && cyc < target; i++) next_cyc();
    endtask

    // Waits for ack_o[r] at a negedge, then drops req_i[r] while still in the ack cycle.
    task automatic wait_ack(input int r, input bit drop);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_i);
            if (ack_o[r]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout req%0d: got none expected pulse (cycle %0d)", r, cyc);
        end
        if (drop) req_i[r] = 1'b0;
    endtask

    // Monitor: every change of dom_reset_n_o and every ack pulse must match the queue head.
    initial begin
        logic [3:0] prev_dom;
        dom_ev_t    de;
        ack_ev_t    ae;
        prev_dom = 4'hF;
        forever begin
            @(negedge clk_i);
            if (dom_reset_n_o !== prev_dom) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL dom_unexpected: got %b at cycle %0d expected no change", dom_reset_n_o, cyc);
                end else begin
                    de = dq.pop_front();
                    if (de.cyc != cyc || de.val !== dom_reset_n_o) begin
                        errors++;
                        $display("FAIL dom_event: got %b at cycle %0d expected %b at cycle %0d",
                                 dom_reset_n_o, cyc, de.val, de.cyc);
                    end
                end
                prev_dom = dom_reset_n_o;
            end
            if (ack_o != 3'b000) begin
                checks++;
                if (aq.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: got %b at cycle %0d expected none", ack_o, cyc);
                end else begin
                    ae = aq.pop_front();
                    if (ae.cyc != cyc || ae.val !== ack_o) begin
                        errors++;
                        $display("FAIL ack_event: got %b at cycle %0d expected %b at cycle %0d",
                                 ack_o, cyc, ae.val, ae.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        reset_n_i  = 1'b0;
        req_i      = 3'b000;
        dom_mask_i = 12'h000;
        repeat (3) next_cyc();
        check("reset_dom", 32'(dom_reset_n_o), 32'hF);
        check("reset_ack", 32'(ack_o), 32'h0);
        check("reset_busy", 32'(busy_o), 32'h0);
        reset_n_i = 1'b1;
        next_cyc();

        // req0, mask 0101: low t2..t17, dom0 up t18, dom2 up t22, ack t23
        next_cyc();
        t0 = cyc;
        dom_mask_i[3:0] = 4'b0101;
        req_i[0] = 1'b1;
        push_dom(t0 + 2,  4'b1010);
        push_dom(t0 + 18, 4'b1011);
        push_dom(t0 + 22, 4'b1111);
        push_ack(t0 + 23, 3'b001);
        wait_ack(0, 1'b1);

        // req1 and req2 together: req1 first, req2 granted at ack+2
        next_cyc();
        t0 = cyc;
        dom_mask_i[7:4]  = 4'b1000;
        dom_mask_i[11:8] = 4'b0110;
        req_i[1] = 1'b1;
        req_i[2] = 1'b1;
        push_dom(t0 + 2,  4'b0111);
        push_dom(t0 + 18, 4'b1111);
        push_ack(t0 + 19, 3'b010);
        push_dom(t0 + 22, 4'b1001);
        push_dom(t0 + 38, 4'b1011);
        push_dom(t0 + 42, 4'b1111);
        push_ack(t0 + 43, 3'b100);
        wait_ack(1, 1'b1);
        wait_ack(2, 1'b1);

        // pointer wrapped to 0: req0 beats req1
        next_cyc();
        t0 = cyc;
        dom_mask_i[3:0] = 4'b0010;
        dom_mask_i[7:4] = 4'b0100;
        req_i[0] = 1'b1;
        req_i[1] = 1'b1;
        push_dom(t0 + 2,  4'b1101);
        push_dom(t0 + 18, 4'b1111);
        push_ack(t0 + 19, 3'b001);
        push_dom(t0 + 22, 4'b1011);
        push_dom(t0 + 38, 4'b1111);
        push_ack(t0 + 39, 3'b010);
        wait_ack(0, 1'b1);
        wait_ack(1, 1'b1);

        // empty mask: ack two cycles after request, busy for two cycles
        next_cyc();
        t0 = cyc;
        dom_mask_i[3:0] = 4'b0000;
        req_i[0] = 1'b1;
        push_ack(t0 + 2, 3'b001);
        @(negedge clk_i);
        check("empty_busy_t0", 32'(busy_o), 32'h0);
        @(negedge clk_i);
        check("empty_busy_t1", 32'(busy_o), 32'h1);
        @(negedge clk_i);
        check("empty_busy_t2", 32'(busy_o), 32'h1);
        req_i[0] = 1'b0;
        @(negedge clk_i);
        check("empty_busy_t3", 32'(busy_o), 32'h0);
        check("empty_dom", 32'(dom_reset_n_o), 32'hF);

        // reset during ASSERT: domains high and idle at once, ack lost
        next_cyc();
        t0 = cyc;
        dom_mask_i[7:4] = 4'b1111;
        req_i[1] = 1'b1;
        push_dom(t0 + 2, 4'b0000);
        run_to(t0 + 5);
        push_dom(t0 + 5, 4'b1111);
        reset_n_i = 1'b0;
        #1;
        check("midrst_dom", 32'(dom_reset_n_o), 32'hF);
        check("midrst_busy", 32'(busy_o), 32'h0);
        req_i[1] = 1'b0;
        repeat (2) next_cyc();
        reset_n_i = 1'b1;
        repeat (30) next_cyc();

        // re-request after reset runs a full sequence
        t0 = cyc;
        dom_mask_i[7:4] = 4'b0001;
        req_i[1] = 1'b1;
        push_dom(t0 + 2,  4'b1110);
        push_dom(t0 + 18, 4'b1111);
        push_ack(t0 + 19, 3'b010);
        wait_ack(1, 1'b1);

        // req2 held through ack restarts; dropping it mid-RELEASE still acks
        next_cyc();
        t0 = cyc;
        dom_mask_i[11:8] = 4'b0011;
        req_i[2] = 1'b1;
        push_dom(t0 + 2,  4'b1100);
        push_dom(t0 + 18, 4'b1101);
        push_dom(t0 + 22, 4'b1111);
        push_ack(t0 + 23, 3'b100);
        push_dom(t0 + 26, 4'b1100);
        push_dom(t0 + 42, 4'b1101);
        push_dom(t0 + 46, 4'b1111);
        push_ack(t0 + 47, 3'b100);
        run_to(t0 + 43);
        req_i[2] = 1'b0;
        wait_ack(2, 1'b0);

`ifdef TCU_RESET_SEQ_CAUSE_EN
        next_cyc();
        check("cause_after_req2", 32'(cause_o), 32'h2);
        check("cnt_after_three", 32'(rst_cnt_o), 32'h3);
        // 256 back-to-back empty-mask grants for req1: ack every 3 cycles
        t0 = cyc;
        dom_mask_i[7:4] = 4'b0000;
        req_i[1] = 1'b1;
        for (int k = 0; k < 256; k++) push_ack(t0 + 2 + 3 * k, 3'b010);
        run_to(t0 + 2 + 3 * 255);
        @(negedge clk_i);
        req_i[1] = 1'b0;
        next_cyc();
        check("cause_req1", 32'(cause_o), 32'h1);
        check("cause_vld", 32'(cause_vld_o), 32'h1);
        check("cnt_saturated", 32'(rst_cnt_o), 32'hFF);
`endif

        repeat (5) next_cyc();
        check("dom_queue_drained", 32'(dq.size()), 32'h0);
        check("ack_queue_drained", 32'(aq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
